// File: rtl/dda_segment_sequencer.sv
// Segment sequencer for the 4-axis DDA: buffers host segments in a FIFO and
// strobes one into the DDA every control period, flagging underrun/overrun.
module dda_segment_sequencer #(
  parameter int PERIOD = 20000,
  parameter int DEPTH  = 8,
  parameter int AW     = 3,
  parameter int WR_LEN = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          seg_valid,
  output logic          seg_ready,
  input  logic [9:0]    seg_n1,
  input  logic [9:0]    seg_n2,
  input  logic [9:0]    seg_n3,
  input  logic [9:0]    seg_n4,
  input  logic          start,
  input  logic          stop,
  input  logic          clr_flags,
  output logic [9:0]    N1,
  output logic [9:0]    N2,
  output logic [9:0]    N3,
  output logic [9:0]    N4,
  output logic          WR,
  input  logic          dda_busy,
  output logic          running,
  output logic [AW:0]   fifo_level,
  output logic          underrun,
  output logic          overrun,
  output logic [15:0]   seg_count
);

  localparam int CW = $clog2(PERIOD);
  localparam logic [CW-1:0] CNT_LAST = CW'(PERIOD - 1);
  localparam logic [CW-1:0] WR_END = CW'(WR_LEN);
  localparam logic [AW:0] LEVEL_FULL = (AW + 1)'(DEPTH);

  typedef enum logic {IDLE, ACTIVE} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          stop_pend_q, stop_pend_d;
  logic          wr_q, wr_d;
  logic          running_q, running_d;
  logic [39:0]   n_q, n_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   level_q, level_d;
  logic          ready_q, ready_d;
  logic          under_q, under_d;
  logic          over_q, over_d;
  logic [15:0]   count_q, count_d;
  logic [39:0]   mem_q [DEPTH];

  logic push, load, pop;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    stop_pend_d = stop_pend_q;
    n_d         = n_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    under_d     = under_q & ~clr_flags;
    over_d      = over_q & ~clr_flags;

    push = seg_valid & ready_q;
    load = (state_q == ACTIVE) && (cnt_q == '0);
    pop  = load && (level_q != '0);

    // An empty FIFO at the boundary zero-fills the DDA rather than replaying.
    if (load) begin
      if (pop) begin
        n_d      = mem_q[rd_ptr_q];
        rd_ptr_d = rd_ptr_q + AW'(1);
        count_d  = count_q + 16'd1;
      end else begin
        n_d     = '0;
        under_d = 1'b1;
      end
      if (dda_busy) over_d = 1'b1;
    end

    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    level_d = level_q + (AW + 1)'(push) - (AW + 1)'(pop);
    ready_d = level_d < LEVEL_FULL;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (start && !stop) state_d = ACTIVE;
      end
      default: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (stop_pend_q) begin
            state_d     = IDLE;
            stop_pend_d = 1'b0;
          end else if (stop) begin
            stop_pend_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
          if (stop) stop_pend_d = 1'b1;
        end
      end
    endcase

    running_d = (state_d == ACTIVE);
    wr_d      = (state_d == ACTIVE) && (cnt_d != '0) && (cnt_d <= WR_END);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      stop_pend_q <= 1'b0;
      wr_q        <= 1'b0;
      running_q   <= 1'b0;
      n_q         <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      ready_q     <= 1'b1;
      under_q     <= 1'b0;
      over_q      <= 1'b0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      stop_pend_q <= stop_pend_d;
      wr_q        <= wr_d;
      running_q   <= running_d;
      n_q         <= n_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      ready_q     <= ready_d;
      under_q     <= under_d;
      over_q      <= over_d;
      count_q     <= count_d;
    end
  end

  // Storage needs no reset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {seg_n1, seg_n2, seg_n3, seg_n4};
  end

  assign seg_ready  = ready_q;
  assign fifo_level = level_q;
  assign N1         = n_q[39:30];
  assign N2         = n_q[29:20];
  assign N3         = n_q[19:10];
  assign N4         = n_q[9:0];
  assign WR         = wr_q;
  assign running    = running_q;
  assign underrun   = under_q;
  assign overrun    = over_q;
  assign seg_count  = count_q;

endmodule

// File: tb/tb_dda_segment_sequencer.sv
// Bench for dda_segment_sequencer: directed steps plus random traffic, all
// outputs compared every cycle against a queue-based period model.
module tb_dda_segment_sequencer;

  localparam int PERIOD = 24;
  localparam int DEPTH  = 8;
  localparam int AW     = 3;
  localparam int WR_LEN = 2;

  logic clk = 1'b0;
  always #25 clk = ~clk;

  logic          rst, seg_valid, start, stop, clr_flags, dda_busy;
  logic [9:0]    seg_n1, seg_n2, seg_n3, seg_n4;
  logic          seg_ready, WR, running, underrun, overrun;
  logic [9:0]    N1, N2, N3, N4;
  logic [AW:0]   fifo_level;
  logic [15:0]   seg_count;

  dda_segment_sequencer #(
    .PERIOD(PERIOD), .DEPTH(DEPTH), .AW(AW), .WR_LEN(WR_LEN)
  ) dut (
    .clk(clk), .rst(rst),
    .seg_valid(seg_valid), .seg_ready(seg_ready),
    .seg_n1(seg_n1), .seg_n2(seg_n2), .seg_n3(seg_n3), .seg_n4(seg_n4),
    .start(start), .stop(stop), .clr_flags(clr_flags),
    .N1(N1), .N2(N2), .N3(N3), .N4(N4), .WR(WR),
    .dda_busy(dda_busy), .running(running), .fifo_level(fifo_level),
    .underrun(underrun), .overrun(overrun), .seg_count(seg_count)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: a queue of pending segments, and the activation cycle
  // from which every period boundary is derived by plain modulo arithmetic.
  logic [39:0] m_q[$];
  logic [39:0] m_n = '0;
  bit          m_active = 1'b0;
  bit          m_stop_pend = 1'b0;
  bit          m_under = 1'b0;
  bit          m_over = 1'b0;
  logic [15:0] m_count = '0;
  int          m_cyc = 0;
  int          m_t0 = 0;

  function automatic int phase(input int c);
    return (c - m_t0) % PERIOD;
  endfunction

  task automatic stepModel();
    bit pushed;
    bit do_load;
    if (rst) begin
      m_q.delete();
      m_n = '0;
      m_active = 1'b0;
      m_stop_pend = 1'b0;
      m_under = 1'b0;
      m_over = 1'b0;
      m_count = '0;
    end else begin
      pushed  = seg_valid && (m_q.size() < DEPTH);
      do_load = m_active && (phase(m_cyc) == 0);
      if (clr_flags) begin
        m_under = 1'b0;
        m_over  = 1'b0;
      end
      if (do_load) begin
        if (m_q.size() > 0) begin
          m_n = m_q.pop_front();
          m_count = m_count + 16'd1;
        end else begin
          m_n = '0;
          m_under = 1'b1;
        end
        if (dda_busy) m_over = 1'b1;
      end
      if (pushed) m_q.push_back({seg_n1, seg_n2, seg_n3, seg_n4});
      if (!m_active) begin
        if (start && !stop) begin
          m_active = 1'b1;
          m_t0 = m_cyc + 1;
        end
      end else if (m_stop_pend && phase(m_cyc) == PERIOD - 1) begin
        m_active = 1'b0;
        m_stop_pend = 1'b0;
      end else if (stop) begin
        m_stop_pend = 1'b1;
      end
    end
    m_cyc++;
  endtask

  task automatic checkValue(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic checkOutput();
    int  ph;
    bit  exp_wr;
    ph = phase(m_cyc);
    exp_wr = m_active && (ph >= 1) && (ph <= WR_LEN);
    checkValue("running", 64'(running), 64'(m_active));
    checkValue("WR", 64'(WR), 64'(exp_wr));
    checkValue("N1..N4", 64'({N1, N2, N3, N4}), 64'(m_n));
    checkValue("fifo_level", 64'(fifo_level), 64'(m_q.size()));
    checkValue("seg_ready", 64'(seg_ready), 64'(m_q.size() < DEPTH));
    checkValue("underrun", 64'(underrun), 64'(m_under));
    checkValue("overrun", 64'(overrun), 64'(m_over));
    checkValue("seg_count", 64'(seg_count), 64'(m_count));
  endtask

  task automatic tick();
    @(posedge clk);
    stepModel();
    #1;
    checkOutput();
  endtask

  task automatic applyStimulus(input int cycles);
    repeat (cycles) tick();
  endtask

  task automatic pushSeg(input logic [39:0] s);
    seg_valid = 1'b1;
    {seg_n1, seg_n2, seg_n3, seg_n4} = s;
    tick();
    seg_valid = 1'b0;
  endtask

  function automatic logic [39:0] randSeg();
    logic [39:0] s;
    s = {$urandom, $urandom};
    return s;
  endfunction

  localparam logic [39:0] SEG_A = {10'h119, 10'h005, 10'h200, 10'h031};
  localparam logic [39:0] SEG_B = {10'h2A0, 10'h07F, 10'h101, 10'h000};
  localparam logic [39:0] SEG_C = {10'h0FF, 10'h280, 10'h013, 10'h2C4};
  localparam logic [39:0] SEG_D = {10'h233, 10'h044, 10'h2FE, 10'h010};

  initial begin
    rst = 1'b1; seg_valid = 1'b0; start = 1'b0; stop = 1'b0;
    clr_flags = 1'b0; dda_busy = 1'b0;
    seg_n1 = '0; seg_n2 = '0; seg_n3 = '0; seg_n4 = '0;

    $display("[TB] reset");
    applyStimulus(2);
    rst = 1'b0;
    applyStimulus(2);

    $display("[TB] normal sequencing of three segments");
    pushSeg(SEG_A);
    pushSeg(SEG_B);
    pushSeg(SEG_C);
    checkValue("level_after_3_pushes", 64'(fifo_level), 64'd3);
    start = 1'b1; tick(); start = 1'b0;
    applyStimulus(3 * PERIOD);
    checkValue("seg_count_after_3", 64'(seg_count), 64'd3);
    checkValue("last_segment_C", 64'({N1, N2, N3, N4}), 64'(SEG_C));

    $display("[TB] underrun and flag clear");
    applyStimulus(PERIOD + 2);
    checkValue("underrun_set", 64'(underrun), 64'd1);
    checkValue("zero_fill", 64'({N1, N2, N3, N4}), 64'd0);
    checkValue("seg_count_held", 64'(seg_count), 64'd3);
    clr_flags = 1'b1; tick(); clr_flags = 1'b0;
    checkValue("underrun_cleared", 64'(underrun), 64'd0);

    $display("[TB] overrun with busy DDA");
    pushSeg(SEG_D);
    dda_busy = 1'b1;
    applyStimulus(PERIOD);
    dda_busy = 1'b0;
    checkValue("overrun_set", 64'(overrun), 64'd1);
    checkValue("load_despite_busy", 64'({N1, N2, N3, N4}), 64'(SEG_D));
    checkValue("seg_count_4", 64'(seg_count), 64'd4);

    $display("[TB] stop mid-period");
    stop = 1'b1; tick(); stop = 1'b0;
    applyStimulus(PERIOD);
    checkValue("stopped", 64'(running), 64'd0);
    applyStimulus(2 * PERIOD);

    $display("[TB] start with stop from idle");
    start = 1'b1; stop = 1'b1; tick(); start = 1'b0; stop = 1'b0;
    checkValue("start_stop_idle", 64'(running), 64'd0);
    applyStimulus(3);

    $display("[TB] reset during WR strobe");
    pushSeg(SEG_A);
    pushSeg(SEG_B);
    start = 1'b1; tick(); start = 1'b0;
    applyStimulus(2);
    checkValue("wr_before_reset", 64'(WR), 64'd1);
    rst = 1'b1; tick(); rst = 1'b0;
    checkValue("wr_after_reset", 64'(WR), 64'd0);
    checkValue("level_after_reset", 64'(fifo_level), 64'd0);
    checkValue("overrun_after_reset", 64'(overrun), 64'd0);
    applyStimulus(2);

    $display("[TB] fill FIFO while idle");
    seg_valid = 1'b1;
    for (int i = 0; i < DEPTH + 1; i++) begin
      {seg_n1, seg_n2, seg_n3, seg_n4} = randSeg();
      tick();
    end
    seg_valid = 1'b0;
    checkValue("full_level", 64'(fifo_level), 64'(DEPTH));
    checkValue("full_not_ready", 64'(seg_ready), 64'd0);
    start = 1'b1; tick(); start = 1'b0;
    seg_valid = 1'b1;
    for (int i = 0; i < 2 * PERIOD + 2; i++) begin
      {seg_n1, seg_n2, seg_n3, seg_n4} = randSeg();
      tick();
    end
    seg_valid = 1'b0;

    $display("[TB] random traffic");
    for (int i = 0; i < 10 * PERIOD; i++) begin
      seg_valid = ($urandom_range(0, 2) == 0);
      {seg_n1, seg_n2, seg_n3, seg_n4} = randSeg();
      dda_busy  = ($urandom_range(0, 9) == 0);
      clr_flags = ($urandom_range(0, 29) == 0);
      start     = ($urandom_range(0, 39) == 0);
      stop      = ($urandom_range(0, 79) == 0);
      tick();
    end
    seg_valid = 1'b0; dda_busy = 1'b0; clr_flags = 1'b0;
    start = 1'b0; stop = 1'b0;
    applyStimulus(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
